circ_buf_ctrl: RTL

Pointer and flow controller for the column-wide circular buffer. It owns the buffer's write and read pointers and the occupancy count. It accepts one entry per cycle from the producer and offers a window of PAR_READ consecutive entries to the consumer, which retires 0..PAR_READ entries per handshake. It drives the memory's write enable and addresses and sits between the input streamer and the parallel-read datapath.

---
 rtl/circ_buf_pkg.sv | 22 ++
 rtl/ptr_wrap_add.sv | 22 ++
 rtl/circ_buf_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/circ_buf_pkg.sv
// Shared width helpers and pointer wrap arithmetic for the column-wide
// circular buffer controller and anything that reasons about its pointers.
package circ_buf_pkg;

  function automatic int pw_of(input int columns);
    return $clog2(columns);
  endfunction

  function automatic int sw_of(input int par_read);
    return $clog2(par_read + 1);
  endfunction

  // ptr + inc never exceeds 2*columns-2, so one conditional subtraction wraps it.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned columns);
    int unsigned x;
    x = ptr + inc;
    return (x >= columns) ? (x - columns) : x;
  endfunction

endpackage

// File: rtl/ptr_wrap_add.sv
// Combinational pointer-plus-increment with modulo-COLUMNS wrap, evaluated in
// one extra bit so the carry past the last slot is visible before wrapping.
module ptr_wrap_add
  import circ_buf_pkg::*;
#(
  parameter int COLUMNS = 32,
  parameter int INC_W   = 1,
  localparam int PW     = pw_of(COLUMNS)
) (
  input  logic [PW-1:0]    ptr,
  input  logic [INC_W-1:0] inc,
  output logic [PW-1:0]    sum
);

  localparam logic [PW:0] COLS = (PW+1)'(COLUMNS);

  logic [PW:0] raw;

  assign raw = {1'b0, ptr} + (PW+1)'(inc);
  assign sum = (raw >= COLS) ? PW'(raw - COLS) : PW'(raw);

endmodule

// File: rtl/circ_buf_ctrl.sv
// Write/read pointer and occupancy controller for the column-wide circular
// buffer: one entry in per cycle, a PAR_READ-wide window out per cycle.
module circ_buf_ctrl
  import circ_buf_pkg::*;
#(
  parameter int COLUMNS  = 32,
  parameter int PAR_READ = 4,
  localparam int PW      = pw_of(COLUMNS),
  localparam int SW      = sw_of(PAR_READ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic                   wr_en,
  output logic [PW-1:0]          wr_addr,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  input  logic [SW-1:0]          rd_step,
  output logic [PAR_READ*PW-1:0] rd_addr,
  output logic [PW-1:0]          count
);

  localparam logic [PW-1:0] FULL_CNT = PW'(COLUMNS - 1);
  localparam logic [PW-1:0] WIN_CNT  = PW'(PAR_READ);
  localparam logic [SW-1:0] MAX_STEP = SW'(PAR_READ);

  logic [PW-1:0] write_ptr;
  logic [PW-1:0] read_ptr;
  logic [PW-1:0] write_ptr_next;
  logic [PW-1:0] read_ptr_next;
  logic [PW-1:0] count_next;
  logic [SW-1:0] step_clamp;
  logic [SW-1:0] step_eff;
  logic          full;
  logic          rd_fire;

  assign full     = (count == FULL_CNT);
  assign wr_ready = !full;
  assign wr_en    = wr_valid & wr_ready;
  assign wr_addr  = write_ptr;
  assign rd_valid = (count >= WIN_CNT);
  assign rd_fire  = rd_valid & rd_ready;

  // Out-of-range steps saturate silently; a zero step is a peek.
  assign step_clamp = (rd_step > MAX_STEP) ? MAX_STEP : rd_step;
  assign step_eff   = rd_fire ? step_clamp : '0;

  // rd_valid guarantees step_eff <= count, so this never underflows.
  assign count_next = count + PW'(wr_en) - PW'(step_eff);

  ptr_wrap_add #(
    .COLUMNS (COLUMNS),
    .INC_W   (1)
  ) u_wr_inc (
    .ptr (write_ptr),
    .inc (1'b1),
    .sum (write_ptr_next)
  );

  ptr_wrap_add #(
    .COLUMNS (COLUMNS),
    .INC_W   (SW)
  ) u_rd_inc (
    .ptr (read_ptr),
    .inc (step_clamp),
    .sum (read_ptr_next)
  );

  for (genvar i = 0; i < PAR_READ; i++) begin : g_slot
    localparam logic [PW-1:0] OFF = PW'(i);
    logic [PW-1:0] slot_addr;

    ptr_wrap_add #(
      .COLUMNS (COLUMNS),
      .INC_W   (PW)
    ) u_slot (
      .ptr (read_ptr),
      .inc (OFF),
      .sum (slot_addr)
    );

    assign rd_addr[i*PW +: PW] = slot_addr;
  end

  // Flush wins over both handshakes; any entry written alongside it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else if (clear) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (wr_en) begin
        write_ptr <= write_ptr_next;
      end
      if (rd_fire) begin
        read_ptr <= read_ptr_next;
      end
      count <= count_next;
    end
  end

endmodule
